fu_cdb_queue: RTL and testbench
===============================

// Module: fu_cdb_queue
// PURPOSE
//  Per-FU result buffer on the FU side of the CDB request/ack protocol.
//  Captures finished results {rob_tag, v} from an FU pipeline into a small FIFO.
//  Raises done toward the CDB arbiter while non-empty and pops the head on ack.
//  Back-pressures the FU via in_ready so no result is lost while the CDB is busy.
//  One instance per FU; outputs feed fu_out_packets[i], ack comes from cdb ack[i].
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  TAG_W   5   ROB tag width
//  DATA_W  32  result value width
// PORTS
//  clock       in   1              system clock, rising edge
//  reset       in   1              asynchronous, active-high; clears all state
//  in_valid    in   1              FU presents a finished result this cycle
//  in_rob_tag  in   TAG_W          ROB tag of that result
//  in_v        in   DATA_W         result value
//  in_ready    out  1              queue accepts push this cycle
//  done        out  1              CDB request: head entry valid
//  rob_tag     out  TAG_W          head ROB tag (0 when !done)
//  v           out  DATA_W         head value (0 when !done)
//  ack         in   1              CDB grant for this FU; pops head
//  count       out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async): head ptr=0, tail ptr=0, count=0, so done=0, in_ready=1,
//    rob_tag=0, v=0. Any in-flight entry is dropped. Storage is not cleared.
//  - Push = in_valid & in_ready. Writes the entry at tail and increments tail
//    (mod DEPTH) on the clock edge.
//  - Pop = done & ack. Increments head (mod DEPTH) on the clock edge.
//  - ack while !done is ignored. No state change, no underflow.
//  - in_ready = (count != DEPTH), registered-state based. A full queue refuses a
//    push even when the same cycle pops (no full pass-through).
//  - in_valid & !in_ready: the input is ignored. The FU must hold it and retry.
//  - Push and pop in the same cycle: count is unchanged and both pointers advance.
//  - count' = count + push - pop, range 0..DEPTH, never wraps.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
//  - done/rob_tag/v are combinational from head storage and count.
//    Latency push -> done is 1 cycle. Results leave in strict FIFO order.
//  - ack must be combinational-safe: the arbiter derives ack from done in the
//    same cycle. This block has no combinational path from ack to done.
// CONFIGURATION
//  CDB_BYPASS_EN defined:
//    - When count==0 and in_valid, the input is driven directly onto
//      done/rob_tag/v in the same cycle (0-cycle latency).
//    - If ack is also high, the entry is consumed and not written.
//      Pointers and count are unchanged.
//    - If ack is low, the entry is written normally.
//    - Adds a combinational path in_valid -> done.
//  CDB_BYPASS_EN undefined:
//    - No bypass; done depends only on registered state.
// TESTING
//  1 Reset then idle: done=0, in_ready=1, count=0, rob_tag=0, v=0. Assert reset
//    mid-stream with count=3 -> count=0 and done=0 immediately (async).
//  2 Push tag=3,v=0xAAAA with ack held 0 -> next cycle done=1, rob_tag=3,
//    v=0xAAAA. Held until ack=1; after that edge done=0, count=0.
//  3 Push tags 1,2,3,4 with ack=0 -> count=4, in_ready=0. Push tag 5 is ignored.
//    Then ack=1 for 4 cycles -> tags 1,2,3,4 in order, count=0.
//  4 Steady stream, in_valid=1 and ack=1 every cycle, 10 tags -> count stays 1
//    after the first push. Pointers wrap past 3 and all 10 tags exit in order.
//  5 ack=1 with count=0 -> no change; count stays 0 and done stays 0.
//  6 (CDB_BYPASS_EN) count=0, push tag=7 with ack=1 -> done=1 and rob_tag=7 in
//    the same cycle, count stays 0. Same with ack=0 -> count=1 next cycle.

Source files
------------

// File: rtl/fu_cdb_queue.sv
// fu_cdb_queue: per-FU result FIFO on the FU side of the CDB request/ack protocol.
// It holds finished results {rob_tag, v} until the CDB arbiter grants them.
// done requests the bus while the head entry is valid, and ack pops that entry.
// in_ready back-pressures the FU when every entry is occupied.
// Optional feature: define CDB_BYPASS_EN to let a result arriving at an empty
// queue reach done/rob_tag/v in the same cycle it is presented.
module fu_cdb_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [TAG_W-1:0]           in_rob_tag,
   input  logic [DATA_W-1:0]          in_v,
   output logic                       in_ready,
   output logic                       done,
   output logic [TAG_W-1:0]           rob_tag,
   output logic [DATA_W-1:0]          v,
   input  logic                       ack,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;
   logic [TAG_W-1:0]  tag_mem_r [DEPTH];
   logic [DATA_W-1:0] val_mem_r [DEPTH];

   logic              empty_s;
   logic              full_s;
   logic              bypass_s;
   logic              push_s;
   logic              pop_s;

   // Derive occupancy flags and the push/pop qualifiers from registered state.
   always_comb begin
      empty_s  = (count_r == {CNT_W{1'b0}});
      full_s   = (count_r == CNT_W'(DEPTH));
`ifdef CDB_BYPASS_EN
      // An arriving result that is granted while the queue is empty never
      // touches storage: it is handed straight to the bus.
      bypass_s = empty_s & in_valid & ack;
`else
      bypass_s = 1'b0;
`endif
      // Full queue refuses the push even if the head pops this cycle.
      push_s   = in_valid & ~full_s & ~bypass_s;
      // Only a real stored head can be popped; ack on an empty queue is ignored.
      pop_s    = ~empty_s & ack;
   end

   // Drive the CDB request and head fields; zeros whenever nothing is offered.
   always_comb begin
      done    = 1'b0;
      rob_tag = {TAG_W{1'b0}};
      v       = {DATA_W{1'b0}};
      if (!empty_s) begin
         done    = 1'b1;
         rob_tag = tag_mem_r[head_r];
         v       = val_mem_r[head_r];
      end
`ifdef CDB_BYPASS_EN
      else if (in_valid) begin
         done    = 1'b1;
         rob_tag = in_rob_tag;
         v       = in_v;
      end
`endif
      else begin
         done    = 1'b0;
      end
   end

   // Back-pressure depends only on registered occupancy.
   always_comb begin
      in_ready = ~full_s;
      count    = count_r;
   end

   // Head/tail pointers and occupancy counter; async reset drops all entries.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage is written on push only and is deliberately not reset.
   always_ff @(posedge clock) begin
      if (push_s) begin
         tag_mem_r[tail_r] <= in_rob_tag;
         val_mem_r[tail_r] <= in_v;
      end
   end

endmodule

// File: tb/tb_fu_cdb_queue.sv
// Self-checking bench for fu_cdb_queue: a queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fu_cdb_queue;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;

   logic              clock;
   logic              reset;
   logic              in_valid;
   logic [TAG_W-1:0]  in_rob_tag;
   logic [DATA_W-1:0] in_v;
   logic              in_ready;
   logic              done;
   logic [TAG_W-1:0]  rob_tag;
   logic [DATA_W-1:0] v;
   logic              ack;
   logic [2:0]        count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] val;
   } entry_t;

   entry_t model_q[$];
   int     out_log[$];

   fu_cdb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_rob_tag(in_rob_tag),
      .in_v(in_v), .in_ready(in_ready), .done(done), .rob_tag(rob_tag), .v(v),
      .ack(ack), .count(count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO semantics expressed directly on a queue.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_q.delete();
      end else begin
         bit can_push, can_pop, byp;
         entry_t e;
         byp = 1'b0;
`ifdef CDB_BYPASS_EN
         byp = (model_q.size() == 0) && in_valid && ack;
`endif
         can_push = in_valid && (model_q.size() != DEPTH) && !byp;
         can_pop  = ack && (model_q.size() != 0);
         if (can_pop) void'(model_q.pop_front());
         if (can_push) begin
            e.tag = in_rob_tag;
            e.val = in_v;
            model_q.push_back(e);
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of granted tags.
   always @(negedge clock) begin
      logic              e_done;
      logic [TAG_W-1:0]  e_tag;
      logic [DATA_W-1:0] e_val;
      e_done = 1'b0; e_tag = '0; e_val = '0;
      if (model_q.size() != 0) begin
         e_done = 1'b1; e_tag = model_q[0].tag; e_val = model_q[0].val;
      end
`ifdef CDB_BYPASS_EN
      else if (in_valid && !reset) begin
         e_done = 1'b1; e_tag = in_rob_tag; e_val = in_v;
      end
`endif
      chk("cyc_done", 64'(done), 64'(e_done));
      chk("cyc_tag", 64'(rob_tag), 64'(e_tag));
      chk("cyc_v", 64'(v), 64'(e_val));
      chk("cyc_count", 64'(count), 64'(model_q.size()));
      chk("cyc_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
      if (done && ack && !reset) out_log.push_back(int'(rob_tag));
   end

   task automatic step(input logic iv, input int tag, input int val, input logic a);
      in_valid   = iv;
      in_rob_tag = TAG_W'(tag);
      in_v       = DATA_W'(val);
      ack        = a;
      @(posedge clock);
      #1;
   endtask

   task automatic chk_log(input string name, input int exp[]);
      chk({name, "_len"}, 64'(out_log.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < out_log.size(); i++)
         chk(name, 64'(out_log[i]), 64'(exp[i]));
      out_log.delete();
   endtask

   initial begin
      int exp4[];
      reset = 1'b1; in_valid = 1'b0; in_rob_tag = '0; in_v = '0; ack = 1'b0;
      #12;
      reset = 1'b0;
      @(posedge clock); #1;

      // 1: idle after reset
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_tag", 64'(rob_tag), 64'd0);
      chk("rst_v", 64'(v), 64'd0);

      // 2: single push held until ack
      step(1'b1, 3, 32'hAAAA, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      chk("one_done", 64'(done), 64'd1);
      chk("one_tag", 64'(rob_tag), 64'd3);
      chk("one_v", 64'(v), 64'hAAAA);
      step(1'b0, 0, 0, 1'b0);
      chk("one_hold", 64'(done), 64'd1);
      step(1'b0, 0, 0, 1'b1);
      chk("one_pop_done", 64'(done), 64'd0);
      chk("one_pop_count", 64'(count), 64'd0);
      chk_log("one_log", '{3});

      // 3: fill, refused push, drain in order
      for (int t = 1; t <= 4; t++) step(1'b1, t, 32'h100 + t, 1'b0);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(in_ready), 64'd0);
      step(1'b1, 5, 32'h105, 1'b0);
      chk("full_refuse", 64'(count), 64'd4);
      for (int t = 0; t < 4; t++) step(1'b0, 0, 0, 1'b1);
      chk("drain_count", 64'(count), 64'd0);
      chk_log("fifo_order", '{1, 2, 3, 4});

      // 4: steady stream with wrap
      for (int t = 0; t < 10; t++) begin
         step(1'b1, 10 + t, 32'h200 + t, 1'b1);
`ifdef CDB_BYPASS_EN
         chk("stream_count", 64'(count), 64'd0);
`else
         chk("stream_count", 64'(count), 64'd1);
`endif
      end
      step(1'b0, 0, 0, 1'b1);
      chk("stream_end", 64'(count), 64'd0);
      chk_log("stream_order", '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19});

      // 5: ack on empty queue
      step(1'b0, 0, 0, 1'b1);
      step(1'b0, 0, 0, 1'b1);
      chk("empty_ack_count", 64'(count), 64'd0);
      chk("empty_ack_done", 64'(done), 64'd0);
      ack = 1'b0;

`ifdef CDB_BYPASS_EN
      // 6: same-cycle bypass
      in_valid = 1'b1; in_rob_tag = 5'd7; in_v = 32'h77; ack = 1'b1;
      #1;
      chk("byp_done", 64'(done), 64'd1);
      chk("byp_tag", 64'(rob_tag), 64'd7);
      @(posedge clock); #1;
      chk("byp_count", 64'(count), 64'd0);
      ack = 1'b0;
      #1;
      chk("byp_noack_done", 64'(done), 64'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      chk("byp_noack_count", 64'(count), 64'd1);
      step(1'b0, 0, 0, 1'b1);
      chk_log("byp_log", '{7, 7});
`endif

      // 1b: async reset mid-stream with three entries
      for (int t = 0; t < 3; t++) step(1'b1, 20 + t, 32'h300 + t, 1'b0);
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(count), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      step(1'b0, 0, 0, 1'b0);
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      out_log.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
